conf_int_mac_job_arbiter: RTL and testbench

- Shares one conf_int_mac__noFF__arch_agnos datapath between two requesters.
- Each requester submits a "job": a stream of signed operand pairs, terminated by a last flag.
- The arbiter grants the MAC for a whole job, round-robin. It sequences accumulator clear and enable, waits out the MAC pipeline latency, then returns the accumulated result through a valid/ready response port.

---
 rtl/conf_int_mac_job_arbiter.sv | 142 ++++++++++++++
 tb/tb_conf_int_mac_job_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_int_mac_job_arbiter.sv
// Job-level round-robin arbiter that shares one external MAC datapath
// between two requesters. A grant covers a whole job (pairs up to a last
// flag or MAX_LEN pairs); the accumulated result is returned on a
// valid/ready response port once the MAC pipeline has drained.
module conf_int_mac_job_arbiter #(
  parameter int OP_BITWIDTH        = 32,
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int MAC_LATENCY        = 1,
  parameter int MAX_LEN            = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [OP_BITWIDTH-1:0]        req0_a,
  input  logic [OP_BITWIDTH-1:0]        req0_b,
  input  logic                          req0_last,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [OP_BITWIDTH-1:0]        req1_a,
  input  logic [OP_BITWIDTH-1:0]        req1_b,
  input  logic                          req1_last,
  output logic [OP_BITWIDTH-1:0]        mac_a,
  output logic [OP_BITWIDTH-1:0]        mac_b,
  output logic                          mac_en,
  output logic                          mac_clr,
  input  logic [DATA_PATH_BITWIDTH-1:0] mac_d,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic [DATA_PATH_BITWIDTH-1:0] rsp_data,
  output logic                          rsp_ovf,
  output logic                          busy
);

  // Pair counter only needs to reach MAX_LEN-1: the MAX_LEN-th pair ends the job.
  localparam int CNT_W = $clog2(MAX_LEN);
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESP} state_t;

  state_t                        state_reg;
  logic                          grant_reg;
  logic                          rr_ptr_reg;
  logic                          ovf_reg;
  logic [CNT_W-1:0]              pair_cnt_reg;
  logic [LAT_W-1:0]              lat_cnt_reg;
  logic                          rsp_valid_reg;
  logic                          rsp_id_reg;
  logic                          rsp_ovf_reg;
  logic [DATA_PATH_BITWIDTH-1:0] rsp_data_reg;

  logic                   in_stream;
  logic                   sel_valid;
  logic                   sel_last;
  logic [OP_BITWIDTH-1:0] sel_a;
  logic [OP_BITWIDTH-1:0] sel_b;
  logic                   accept;
  logic                   at_max;

  // Operand/handshake muxing toward the granted requester; everything is quiet outside STREAM.
  always_comb begin
    in_stream  = (state_reg == STREAM);
    sel_valid  = grant_reg ? req1_valid : req0_valid;
    sel_last   = grant_reg ? req1_last  : req0_last;
    sel_a      = grant_reg ? req1_a     : req0_a;
    sel_b      = grant_reg ? req1_b     : req0_b;
    req0_ready = in_stream & ~grant_reg;
    req1_ready = in_stream &  grant_reg;
    accept     = in_stream & sel_valid;
    at_max     = (pair_cnt_reg == CNT_W'(MAX_LEN - 1));
    mac_en     = accept;
    mac_clr    = accept & (pair_cnt_reg == '0);
    mac_a      = in_stream ? sel_a : '0;
    mac_b      = in_stream ? sel_b : '0;
    busy       = (state_reg != IDLE);
    rsp_valid  = rsp_valid_reg;
    rsp_id     = rsp_id_reg;
    rsp_data   = rsp_data_reg;
    rsp_ovf    = rsp_ovf_reg;
  end

  // Job sequencer: grant, stream pairs, wait out MAC latency, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= 1'b0;
      rr_ptr_reg    <= 1'b1;
      ovf_reg       <= 1'b0;
      pair_cnt_reg  <= '0;
      lat_cnt_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_ovf_reg   <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          pair_cnt_reg <= '0;
          lat_cnt_reg  <= '0;
          ovf_reg      <= 1'b0;
          if (req0_valid | req1_valid) begin
            // On contention the requester that was not served last wins.
            grant_reg <= (req0_valid & req1_valid) ? ~rr_ptr_reg : req1_valid;
            state_reg <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            pair_cnt_reg <= pair_cnt_reg + CNT_W'(1);
            if (sel_last || at_max) begin
              // A last flag on the MAX_LEN-th pair is a clean end, not a truncation.
              ovf_reg     <= ~sel_last;
              lat_cnt_reg <= '0;
              state_reg   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (lat_cnt_reg == LAT_W'(MAC_LATENCY - 1)) begin
            rsp_data_reg  <= mac_d;
            rsp_id_reg    <= grant_reg;
            rsp_ovf_reg   <= ovf_reg;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rr_ptr_reg    <= grant_reg;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conf_int_mac_job_arbiter.sv
// Directed bench for conf_int_mac_job_arbiter with a job-level scoreboard,
// a behavioural MAC, and per-cycle protocol checks.
module tb_conf_int_mac_job_arbiter;

  localparam int W     = 32;
  localparam int MAXL  = 4;
  localparam int MLAT  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    rv = 2'b00;
  logic [W-1:0]  ra [2];
  logic [W-1:0]  rb [2];
  logic [1:0]    rl = 2'b00;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  mac_a, mac_b, mac_d;
  logic          mac_en, mac_clr;
  logic          rsp_valid, rsp_id, rsp_ovf, busy;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_data;

  always #5 clk = ~clk;

  conf_int_mac_job_arbiter #(
    .OP_BITWIDTH(W), .DATA_PATH_BITWIDTH(W), .MAC_LATENCY(MLAT), .MAX_LEN(MAXL)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]), .req0_last(rl[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]), .req1_last(rl[1]),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr), .mac_d(mac_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .busy(busy)
  );

  // Behavioural MAC with one cycle of latency: clr loads, en accumulates.
  logic [W-1:0] acc = '0;
  always @(posedge clk) begin
    if (mac_en) acc <= mac_clr ? W'($signed(mac_a) * $signed(mac_b))
                               : acc + W'($signed(mac_a) * $signed(mac_b));
  end
  assign mac_d = acc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Job descriptions per requester: operands, last flag, idle gap after the pair.
  int pa [2][16];
  int pb [2][16];
  bit pl [2][16];
  int pg [2][16];
  int pn [2];

  typedef struct { logic id; logic [W-1:0] data; logic ovf; } rsp_t;
  rsp_t exp_q [$];

  task automatic set_pair(input int id, input int k, input int a, input int b, input bit l, input int g);
    pa[id][k] = a; pb[id][k] = b; pl[id][k] = l; pg[id][k] = g;
  endtask

  // Reference: split the pair list into jobs (last flag or MAX_LEN pairs) and sum products.
  task automatic model_push(input int id);
    int sum = 0;
    int cnt = 0;
    rsp_t r;
    for (int k = 0; k < pn[id]; k++) begin
      sum += pa[id][k] * pb[id][k];
      cnt++;
      if (pl[id][k] || cnt == MAXL) begin
        r.id = id[0]; r.data = sum; r.ovf = !pl[id][k];
        exp_q.push_back(r);
        sum = 0; cnt = 0;
      end
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 1) ? req1_ready : req0_ready;
  endfunction

  // Holds the current pair until the DUT accepts it; returns just after the accepting edge.
  task automatic wait_acc(input int id);
    int t = 0;
    forever begin
      @(negedge clk);
      if (rdy(id)) break;
      t++;
      if (t > 200) begin
        errors++; checks++;
        $display("FAIL accept_timeout req%0d", id);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input int id);
    @(posedge clk); #1;
    for (int k = 0; k < pn[id]; k++) begin
      rv[id] = 1'b1; ra[id] = pa[id][k]; rb[id] = pb[id][k]; rl[id] = pl[id][k];
      wait_acc(id);
      rv[id] = 1'b0; rl[id] = 1'b0;
      repeat (pg[id][k]) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_rv();
    int t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 300) begin @(negedge clk); t++; end
    chk("rsp_valid_timeout", rsp_valid, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && t < 400) begin @(negedge clk); t++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_mac_en"}, mac_en, 0);
    chk({tag, "_mac_clr"}, mac_clr, 0);
    chk({tag, "_mac_a"}, mac_a, 0);
    chk({tag, "_mac_b"}, mac_b, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_ovf"}, rsp_ovf, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Per-cycle compare process: handshake/MAC strobes, idle quietness, response hold and scoreboard.
  logic         first_pend = 1'b1;
  logic         hold_prev = 1'b0;
  logic         h_id, h_ovf;
  logic [W-1:0] h_data;
  logic         last_id;
  logic [W-1:0] last_data;
  logic         last_ovf;
  int           en_cnt = 0;
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      first_pend = 1'b1;
      hold_prev  = 1'b0;
    end else begin
      chk("mac_en", mac_en, (rv[0] & req0_ready) | (rv[1] & req1_ready));
      chk("ready_exclusive", req0_ready & req1_ready, 0);
      if (mac_en) begin
        chk("mac_a", mac_a, req1_ready ? ra[1] : ra[0]);
        chk("mac_b", mac_b, req1_ready ? rb[1] : rb[0]);
        chk("mac_clr_first", mac_clr, first_pend);
        first_pend = 1'b0;
        en_cnt++;
      end else begin
        chk("mac_clr_no_en", mac_clr, 0);
      end
      if (!busy) begin
        chk("idle_ready", {req1_ready, req0_ready}, 0);
        chk("idle_mac_a", mac_a, 0);
        chk("idle_mac_b", mac_b, 0);
      end
      if (hold_prev) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, h_data);
        chk("hold_id", rsp_id, h_id);
        chk("hold_ovf", rsp_ovf, h_ovf);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL rsp_unexpected actual_id=%0d actual_data=%0h required=none", rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_ovf", rsp_ovf, e.ovf);
        end
        last_id = rsp_id; last_data = rsp_data; last_ovf = rsp_ovf;
        first_pend = 1'b1;
      end
      hold_prev = rsp_valid && !rsp_ready;
      h_data = rsp_data; h_id = rsp_id; h_ovf = rsp_ovf;
    end
  end

  initial begin
    ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
    pn[0] = 0; pn[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Single job: 2*3 + 4*5 + (-1)*7 = 19.
    pn[0] = 3;
    set_pair(0, 0, 2, 3, 0, 0);
    set_pair(0, 1, 4, 5, 0, 0);
    set_pair(0, 2, -1, 7, 1, 0);
    model_push(0);
    drive(0);
    wait_rv();
    chk("t1_data", rsp_data, 19);
    chk("t1_id", rsp_id, 0);
    chk("t1_ovf", rsp_ovf, 0);
    @(negedge clk);
    chk("t1_valid_one_cycle", rsp_valid, 0);
    wait_idle();

    // Contention from reset: req0 then req1, twice.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pn[0] = 1; set_pair(0, 0, 1, 1, 1, 0);
      pn[1] = 1; set_pair(1, 0, 3, 3, 1, 0);
      model_push(0);
      model_push(1);
      fork
        drive(0);
        drive(1);
      join
      wait_idle();
      chk("t2_last_id", last_id, 1);
      chk("t2_last_data", last_data, 9);
    end

    // Valid gaps: 5*(-2) + 6*1 = -4 with exactly two accumulate strobes.
    pn[1] = 2;
    set_pair(1, 0, 5, -2, 0, 3);
    set_pair(1, 1, 6, 1, 1, 0);
    model_push(1);
    en_cnt = 0;
    drive(1);
    wait_idle();
    chk("t3_en_count", en_cnt, 2);
    chk("t3_data", last_data, -4);
    chk("t3_id", last_id, 1);

    // Response backpressure with req0 already waiting for its next job.
    @(posedge clk); #1 rsp_ready = 1'b0;
    pn[0] = 1; set_pair(0, 0, 2, 2, 1, 0);
    model_push(0);
    drive(0);
    pn[0] = 1; set_pair(0, 0, 1, 5, 1, 0);
    model_push(0);
    fork
      drive(0);
    join_none
    wait_rv();
    for (int i = 0; i < 5; i++) begin
      chk("t4_waiting_ready", req0_ready, 0);
      chk("t4_data", rsp_data, 4);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_at_handshake", req0_ready, 0);
    @(negedge clk);
    chk("t4_ready_idle_cycle", req0_ready, 0);
    @(negedge clk);
    chk("t4_ready_granted", req0_ready, 1);
    wait fork;
    wait_idle();
    chk("t4_second_data", last_data, 5);

    // Truncation at MAX_LEN: six (1,1) pairs, last only on the sixth -> 4 (ovf) then 2.
    pn[0] = 6;
    for (int k = 0; k < 6; k++) set_pair(0, k, 1, 1, (k == 5), 0);
    model_push(0);
    drive(0);
    wait_idle();
    chk("t5_tail_data", last_data, 2);
    chk("t5_tail_ovf", last_ovf, 0);
    // Last flag on the MAX_LEN-th pair: clean end, 4*(1*2) = 8.
    pn[1] = 4;
    for (int k = 0; k < 4; k++) set_pair(1, k, 1, 2, (k == 3), 0);
    model_push(1);
    drive(1);
    wait_idle();
    chk("t5_exact_data", last_data, 8);
    chk("t5_exact_ovf", last_ovf, 0);

    // Reset in the middle of a job: nothing returned, then a clean fresh job.
    @(posedge clk); #1;
    rv[0] = 1'b1; ra[0] = 7; rb[0] = 7; rl[0] = 1'b0;
    wait_acc(0);
    ra[0] = 8; rb[0] = 8;
    wait_acc(0);
    rv[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    pn[0] = 2;
    set_pair(0, 0, 2, 2, 0, 0);
    set_pair(0, 1, 3, 3, 1, 0);
    model_push(0);
    drive(0);
    wait_idle();
    chk("t6_data", last_data, 13);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
